board_arbiter: RTL and testbench

Shares the single-port board RAM (snake/food/wall cell codes) between the `draw` pixel pipeline and the game-logic block. `draw` reads cells every active-video cycle at a fixed latency and always has priority. Game writes are posted into a small write buffer and drained in idle cycles. Game reads wait until the buffer is empty and `draw` is idle. The block sits between `draw`, the game FSM and the board RAM (1-cycle read latency), all in the 75 MHz pixel clock domain.

---
 rtl/board_arbiter.sv | 170 +++++++++++++++++
 tb/tb_board_arbiter.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_arbiter.sv
// board_arbiter
//
// Shares the single-port board RAM (snake/food/wall cell codes) between the
// draw pixel pipeline and the game-logic block, all in the pixel clock domain.
//   - draw reads own the RAM slot whenever draw_req is high and are never
//     stalled. A result appears two cycles after the request cycle.
//   - game writes are posted into a small FIFO and drained in cycles that
//     draw does not use.
//   - game reads are granted only when draw is idle and the FIFO is empty,
//     so a read always sees every write accepted before it.
//
// Ports:
//   clk, rst                 pixel clock; synchronous active-high reset
//   draw_req, draw_addr      draw read request (one per cycle)
//   draw_data, draw_valid    draw read result; the strobe is registered
//   game_req, game_we,       game request; the fields are held until
//   game_addr, game_wdata    game_gnt is seen at a rising edge
//   game_gnt                 combinational accept
//   game_rdata, game_rvalid  game read result; single-cycle strobe
//   mem_en, mem_we,          registered RAM command
//   mem_addr, mem_wdata
//   mem_rdata                RAM read data, 1 cycle after a read command
//   wbuf_count               number of posted writes not yet in RAM

module board_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 4,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          draw_req,
    input  logic [ADDR_W-1:0]             draw_addr,
    output logic [DATA_W-1:0]             draw_data,
    output logic                          draw_valid,

    input  logic                          game_req,
    input  logic                          game_we,
    input  logic [ADDR_W-1:0]             game_addr,
    input  logic [DATA_W-1:0]             game_wdata,
    output logic                          game_gnt,
    output logic [DATA_W-1:0]             game_rdata,
    output logic                          game_rvalid,

    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,

    output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Posted-write FIFO storage. The pointers wrap naturally because the
    // depth is a power of two.
    logic [ADDR_W-1:0] wbuf_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] wbuf_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wbuf_full;
    logic              wbuf_empty;

    // Slot owner for the current cycle. At most one of these is high.
    logic              slot_draw;
    logic              slot_drain;
    logic              slot_gread;
    logic [ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0] slot_wdata;

    logic              push;
    logic              pop;

    // Tag shift registers. Bit 0 is loaded together with the RAM command.
    // Bit 1 lines up with mem_rdata for that command.
    logic [1:0]        draw_vld_pipe;
    logic [1:0]        game_vld_pipe;

    assign wbuf_full  = (wbuf_count == CNT_W'(WBUF_DEPTH));
    assign wbuf_empty = (wbuf_count == '0);

    // Fixed-priority slot assignment: draw, then drain, then game read.
    always_comb begin
        slot_draw  = draw_req;
        slot_drain = ~draw_req & ~wbuf_empty;
        slot_gread = ~draw_req & wbuf_empty & game_req & ~game_we;
    end

    always_comb begin
        slot_addr  = '0;
        slot_wdata = '0;
        if (slot_draw) begin
            slot_addr = draw_addr;
        end else if (slot_drain) begin
            slot_addr  = wbuf_addr[rd_ptr];
            slot_wdata = wbuf_data[rd_ptr];
        end else if (slot_gread) begin
            slot_addr = game_addr;
        end
    end

    // Write acceptance looks only at the occupancy at the start of the
    // cycle. A drain in the same cycle does not free a slot early, so a full
    // buffer always refuses. A read is granted only in the cycle it owns the
    // RAM slot. While in reset, the grant is held low so that nothing is
    // pushed into a buffer that is being cleared.
    assign game_gnt = ~rst & game_req & (game_we ? ~wbuf_full : slot_gread);
    assign push     = game_gnt & game_we;
    assign pop      = slot_drain;

    // FIFO payload. This storage has no reset because the pointers and the
    // count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            wbuf_addr[wr_ptr] <= game_addr;
            wbuf_data[wr_ptr] <= game_wdata;
        end
    end

    // FIFO control. On reset, buffered writes are dropped and never reach
    // the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wbuf_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   wbuf_count <= wbuf_count + CNT_W'(1);
                2'b01:   wbuf_count <= wbuf_count - CNT_W'(1);
                default: wbuf_count <= wbuf_count;
            endcase
        end
    end

    // Registered RAM command and the read-tag pipeline. Clearing the tags
    // on reset suppresses results for reads issued before the reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            draw_vld_pipe <= '0;
            game_vld_pipe <= '0;
        end else begin
            mem_en        <= slot_draw | slot_drain | slot_gread;
            mem_we        <= slot_drain;
            mem_addr      <= slot_addr;
            mem_wdata     <= slot_wdata;
            draw_vld_pipe <= {draw_vld_pipe[0], slot_draw};
            game_vld_pipe <= {game_vld_pipe[0], slot_gread};
        end
    end

    assign draw_valid  = draw_vld_pipe[1];
    assign game_rvalid = game_vld_pipe[1];

    // Read data comes straight from the RAM port. Each data output is masked
    // by its own strobe, so it is zero after reset and outside its result
    // cycle.
    assign draw_data  = draw_valid  ? mem_rdata : '0;
    assign game_rdata = game_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_board_arbiter.sv
// tb_board_arbiter
//
// Bench for board_arbiter. It contains a behavioural board RAM with a 1-cycle
// registered read and a back-door preload port. Each scenario is a directed
// task. The last task drives random traffic and compares the DUT with a
// queue-based reference model.

module tb_board_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          draw_req;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_data;
    logic          draw_valid;
    logic          game_req;
    logic          game_we;
    logic [AW-1:0] game_addr;
    logic [DW-1:0] game_wdata;
    logic          game_gnt;
    logic [DW-1:0] game_rdata;
    logic          game_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    wbuf_count;

    int total = 0;
    int bad   = 0;

    // Board RAM model.
    logic [DW-1:0] ram [0:1023];
    logic [DW-1:0] rd_q;
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        rd_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = rd_q;

    board_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .draw_req(draw_req), .draw_addr(draw_addr),
        .draw_data(draw_data), .draw_valid(draw_valid),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
        .game_wdata(game_wdata), .game_gnt(game_gnt),
        .game_rdata(game_rdata), .game_rvalid(game_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wbuf_count(wbuf_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 50000 cycles");
        $fatal(1);
    end

    task automatic preload(input int a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = AW'(a); pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Issues one game transfer and holds the request until it is granted.
    // For a read, it also waits for the result. ok=0 means that a bound
    // expired.
    task automatic game_xfer(input logic we, input int a, input logic [DW-1:0] d,
                             output logic [DW-1:0] rd, output int lat, output bit ok);
        int n;
        ok = 1'b0; rd = '0; lat = 0;
        @(posedge clk); #1;
        game_req = 1'b1; game_we = we; game_addr = AW'(a); game_wdata = d;
        n = 0;
        @(negedge clk);
        while (!game_gnt && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!game_gnt) begin
            game_req = 1'b0;
            return;
        end
        @(posedge clk); #1;
        game_req = 1'b0;
        if (!we) begin
            do begin
                @(negedge clk);
                lat++;
            end while (!game_rvalid && lat < 10);
            if (!game_rvalid) return;
            rd = game_rdata;
        end
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; draw_req = 1'b0; draw_addr = '0; game_req = 1'b0;
        game_we = 1'b0; game_addr = '0; game_wdata = '0; pl_we = 1'b0;
        pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_mem: en=%b we=%b addr=%0d wdata=%0h, required all 0",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        total++;
        if (draw_valid !== 1'b0 || draw_data !== '0) begin
            bad++;
            $display("FAIL reset_draw: valid=%b data=%0h, required 0", draw_valid, draw_data);
        end
        total++;
        if (game_rvalid !== 1'b0 || game_rdata !== '0) begin
            bad++;
            $display("FAIL reset_game: rvalid=%b rdata=%0h, required 0", game_rvalid, game_rdata);
        end
        total++;
        if (wbuf_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_count: wbuf_count=%0d, required 0", wbuf_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        game_req = 1'b1; game_we = 1'b1; game_addr = AW'(900); game_wdata = '0;
        @(negedge clk);
        total++;
        if (game_gnt !== 1'b1) begin
            bad++;
            $display("FAIL reset_gnt: game_gnt=%b for write into empty buffer, required 1", game_gnt);
        end
        @(posedge clk); #1;
        game_req = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_draw_stream();
        bit exp_v;
        for (int a = 0; a < 16; a++) preload(a, DW'(a));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            draw_req  = (i < 16);
            draw_addr = (i < 16) ? AW'(i) : '0;
            @(negedge clk);
            exp_v = (i >= 2 && i < 18);
            total++;
            if (draw_valid !== exp_v || (exp_v && draw_data !== DW'(i - 2))) begin
                bad++;
                $display("FAIL draw_stream cyc %0d: valid=%b data=%0h, required valid=%b data=%0h",
                         i, draw_valid, draw_data, exp_v, DW'(i - 2));
            end
        end
    endtask

    task automatic test_posted_writes();
        int idx = 0, we_cnt = 0, acc_at = -1, lat;
        bit accept = 0, saw_we = 0, ok;
        logic [DW-1:0] rd;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (accept) idx++;
            accept = 0;
            draw_req = 1'b1; draw_addr = AW'(600);
            game_req = (idx < 5); game_we = 1'b1;
            game_addr = AW'(5 + idx); game_wdata = 4'hA;
            @(negedge clk);
            if (mem_we) saw_we = 1;
            if (game_req && game_gnt) accept = 1;
        end
        total++;
        if (idx !== 4 || game_gnt !== 1'b0 || wbuf_count !== 3'd4) begin
            bad++;
            $display("FAIL posted_active: grants=%0d gnt=%b count=%0d, required 4/0/4",
                     idx, game_gnt, wbuf_count);
        end
        total++;
        if (saw_we) begin
            bad++;
            $display("FAIL posted_no_we: mem_we seen=%b during active line, required 0", saw_we);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (accept) idx++;
            accept = 0;
            draw_req = 1'b0;
            game_req = (idx < 5); game_addr = AW'(5 + idx);
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (game_req && game_gnt) begin
                accept = 1;
                if (acc_at < 0) acc_at = i;
            end
        end
        total++;
        if (acc_at !== 1 || we_cnt !== 5 || wbuf_count !== 3'd0) begin
            bad++;
            $display("FAIL posted_drain: 5th accepted at %0d writes=%0d count=%0d, required 1/5/0",
                     acc_at, we_cnt, wbuf_count);
        end
        for (int a = 5; a < 10; a++) begin
            game_xfer(1'b0, a, '0, rd, lat, ok);
            total++;
            if (!ok || rd !== 4'hA) begin
                bad++;
                $display("FAIL posted_readback addr %0d: ok=%b data=%0h, required 1/a", a, ok, rd);
            end
        end
    endtask

    task automatic test_raw();
        int lat = 0;
        @(posedge clk); #1;
        draw_req = 1'b0;
        game_req = 1'b1; game_we = 1'b1; game_addr = AW'(100); game_wdata = 4'h3;
        @(negedge clk);
        total++;
        if (game_gnt !== 1'b1) begin
            bad++;
            $display("FAIL raw_wgnt: gnt=%b, required 1", game_gnt);
        end
        @(posedge clk); #1;
        game_we = 1'b0;
        @(negedge clk);
        total++;
        if (game_gnt !== 1'b0 || wbuf_count !== 3'd1) begin
            bad++;
            $display("FAIL raw_hold: gnt=%b count=%0d, required 0/1", game_gnt, wbuf_count);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (game_gnt !== 1'b1 || wbuf_count !== 3'd0) begin
            bad++;
            $display("FAIL raw_rgnt: gnt=%b count=%0d, required 1/0", game_gnt, wbuf_count);
        end
        @(posedge clk); #1;
        game_req = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!game_rvalid && lat < 10);
        total++;
        if (lat !== 2 || game_rdata !== 4'h3) begin
            bad++;
            $display("FAIL raw_data: latency=%0d data=%0h, required 2/3", lat, game_rdata);
        end
    endtask

    task automatic test_full_drain_push();
        logic [DW-1:0] rd;
        int lat;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            draw_req = 1'b1; draw_addr = '0;
            game_req = 1'b1; game_we = 1'b1; game_addr = AW'(200 + k); game_wdata = DW'(k + 1);
        end
        @(posedge clk); #1;
        game_addr = AW'(204); game_wdata = 4'h5;
        @(negedge clk);
        total++;
        if (game_gnt !== 1'b0 || wbuf_count !== 3'd4) begin
            bad++;
            $display("FAIL full_hold: gnt=%b count=%0d, required 0/4", game_gnt, wbuf_count);
        end
        @(posedge clk); #1;
        draw_req = 1'b0;
        @(negedge clk);
        total++;
        if (game_gnt !== 1'b0 || wbuf_count !== 3'd4) begin
            bad++;
            $display("FAIL full_drain_cycle: gnt=%b count=%0d, required 0/4", game_gnt, wbuf_count);
        end
        @(posedge clk); #1;
        draw_req = 1'b1;
        @(negedge clk);
        total++;
        if (game_gnt !== 1'b1 || wbuf_count !== 3'd3) begin
            bad++;
            $display("FAIL full_next: gnt=%b count=%0d, required 1/3", game_gnt, wbuf_count);
        end
        @(posedge clk); #1;
        game_req = 1'b0;
        @(negedge clk);
        total++;
        if (wbuf_count !== 3'd4) begin
            bad++;
            $display("FAIL full_refill: count=%0d, required 4", wbuf_count);
        end
        @(posedge clk); #1;
        draw_req = 1'b0;
        repeat (6) @(posedge clk);
        game_xfer(1'b0, 204, '0, rd, lat, ok);
        total++;
        if (!ok || rd !== 4'h5) begin
            bad++;
            $display("FAIL full_readback 204: ok=%b data=%0h, required 1/5", ok, rd);
        end
        game_xfer(1'b0, 200, '0, rd, lat, ok);
        total++;
        if (!ok || rd !== 4'h1) begin
            bad++;
            $display("FAIL full_readback 200: ok=%b data=%0h, required 1/1", ok, rd);
        end
    endtask

    task automatic test_mixed();
        bit            exp_dv, exp_gv, both = 0;
        logic [DW-1:0] exp_d;
        preload(3, 4'h5);
        preload(4, 4'h6);
        preload(7, 4'hC);
        @(posedge clk); #1;
        draw_req = 1'b1; draw_addr = AW'(3);
        game_req = 1'b1; game_we = 1'b0; game_addr = AW'(7);
        @(negedge clk);
        total++;
        if (game_gnt !== 1'b0) begin
            bad++;
            $display("FAIL mixed_gnt_draw: gnt=%b while draw_req, required 0", game_gnt);
        end
        @(posedge clk); #1;
        draw_req = 1'b0;
        @(negedge clk);
        total++;
        if (game_gnt !== 1'b1) begin
            bad++;
            $display("FAIL mixed_gnt_idle: gnt=%b in idle cycle, required 1", game_gnt);
        end
        @(posedge clk); #1;
        draw_req = 1'b1; draw_addr = AW'(4); game_req = 1'b0;
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            exp_dv = (c == 2 || c == 4);
            exp_gv = (c == 3);
            exp_d  = (c == 2) ? 4'h5 : (c == 3) ? 4'hC : 4'h6;
            if (draw_valid && game_rvalid) both = 1;
            total++;
            if (draw_valid !== exp_dv || game_rvalid !== exp_gv ||
                (exp_dv && draw_data !== exp_d) || (exp_gv && game_rdata !== exp_d)) begin
                bad++;
                $display("FAIL mixed cyc %0d: dv=%b dd=%0h gv=%b gd=%0h, required dv=%b gv=%b data=%0h",
                         c, draw_valid, draw_data, game_rvalid, game_rdata, exp_dv, exp_gv, exp_d);
            end
            @(posedge clk); #1;
            draw_req = 1'b0;
        end
        total++;
        if (both) begin
            bad++;
            $display("FAIL mixed_overlap: both strobes high=%b, required 0", both);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_v = 0, seen_we = 0;
        for (int a = 300; a < 303; a++) preload(a, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            draw_req = 1'b1; draw_addr = AW'(3);
            game_req = 1'b1; game_we = 1'b1; game_addr = AW'(300 + k); game_wdata = 4'hF;
        end
        @(posedge clk); #1;
        game_req = 1'b0;
        @(negedge clk);
        total++;
        if (wbuf_count !== 3'd3) begin
            bad++;
            $display("FAIL rstmid_pre: count=%0d, required 3", wbuf_count);
        end
        @(posedge clk); #1;
        rst = 1'b1; draw_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (wbuf_count !== 3'd0) begin
            bad++;
            $display("FAIL rstmid_count: count=%0d, required 0", wbuf_count);
        end
        for (int i = 0; i < 10; i++) begin
            if (draw_valid || game_rvalid) seen_v = 1;
            if (mem_we) seen_we = 1;
            @(negedge clk);
        end
        total++;
        if (seen_v || seen_we) begin
            bad++;
            $display("FAIL rstmid_quiet: valid seen=%b mem_we seen=%b, required 0/0", seen_v, seen_we);
        end
        for (int a = 300; a < 303; a++) begin
            total++;
            if (ram[a] !== 4'h0) begin
                bad++;
                $display("FAIL rstmid_ram %0d: cell=%0h, required 0", a, ram[a]);
            end
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int            due;
        bit            g;
        logic [DW-1:0] d;
    } exp_t;

    // Random traffic on cells 0..15 against a model that keeps the RAM as an
    // array, the posted writes as an in-order queue, and the expected read
    // results as a queue keyed by the cycle when each result is due.
    task automatic test_random();
        wr_t           wq[$];
        exp_t          eq[$];
        wr_t           w;
        logic [DW-1:0] mram [0:15];
        logic [DW-1:0] exp_d;
        bit            exp_gnt, exp_dv, exp_gv, accepted = 0;

        draw_req = 1'b0; game_req = 1'b0;
        repeat (6) @(posedge clk);
        for (int a = 0; a < 16; a++) mram[a] = ram[a];

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            draw_req  = ($urandom_range(0, 99) < 55);
            draw_addr = AW'($urandom_range(0, 15));
            if (accepted) game_req = 1'b0;
            if (!game_req && $urandom_range(0, 99) < 60) begin
                game_req   = 1'b1;
                game_we    = 1'($urandom_range(0, 1));
                game_addr  = AW'($urandom_range(0, 15));
                game_wdata = DW'($urandom_range(0, 15));
            end
            @(negedge clk);

            if (game_req && game_we)  exp_gnt = (wq.size() < DEPTH);
            else if (game_req)        exp_gnt = !draw_req && wq.size() == 0;
            else                      exp_gnt = 1'b0;
            total++;
            if (game_gnt !== exp_gnt) begin
                bad++;
                $display("FAIL rnd_gnt cyc %0d: gnt=%b, required %b", i, game_gnt, exp_gnt);
            end
            total++;
            if (int'(wbuf_count) != wq.size()) begin
                bad++;
                $display("FAIL rnd_count cyc %0d: count=%0d, required %0d", i, wbuf_count, wq.size());
            end

            exp_dv = 0; exp_gv = 0; exp_d = '0;
            if (eq.size() > 0 && eq[0].due == i) begin
                if (eq[0].g) exp_gv = 1;
                else         exp_dv = 1;
                exp_d = eq[0].d;
                void'(eq.pop_front());
            end
            total++;
            if (draw_valid !== exp_dv || game_rvalid !== exp_gv ||
                (exp_dv && draw_data !== exp_d) || (exp_gv && game_rdata !== exp_d)) begin
                bad++;
                $display("FAIL rnd_read cyc %0d: dv=%b dd=%0h gv=%b gd=%0h, required dv=%b gv=%b data=%0h",
                         i, draw_valid, draw_data, game_rvalid, game_rdata, exp_dv, exp_gv, exp_d);
            end

            if (draw_req) begin
                eq.push_back('{i + 2, 1'b0, mram[draw_addr[3:0]]});
            end else if (wq.size() > 0) begin
                w = wq.pop_front();
                mram[w.a[3:0]] = w.d;
            end else if (game_req && !game_we) begin
                eq.push_back('{i + 2, 1'b1, mram[game_addr[3:0]]});
            end
            if (game_req && game_we && exp_gnt) wq.push_back('{game_addr, game_wdata});
            accepted = game_req && exp_gnt;
        end

        @(posedge clk); #1;
        game_req = 1'b0; draw_req = 1'b0;
        repeat (DEPTH + 4) @(posedge clk);
        while (wq.size() > 0) begin
            w = wq.pop_front();
            mram[w.a[3:0]] = w.d;
        end
        @(negedge clk);
        total++;
        if (wbuf_count !== 3'd0) begin
            bad++;
            $display("FAIL rnd_final_count: count=%0d, required 0", wbuf_count);
        end
        for (int a = 0; a < 16; a++) begin
            total++;
            if (ram[a] !== mram[a]) begin
                bad++;
                $display("FAIL rnd_final_ram %0d: cell=%0h, required %0h", a, ram[a], mram[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_draw_stream();
        test_posted_writes();
        test_raw();
        test_full_drain_push();
        test_mixed();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
